// File: rtl/uart_tx.sv
// Oversampled UART transmitter: write FIFO feeding a start/data/stop framer.
// Bit timing comes from the shared oversample tick used by the receiver.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_CLK,
  input  logic                          i_RESET_n,
  input  logic                          i_Sample_Tick,
  input  logic                          i_TX_DV,
  input  logic [DATA_BITS-1:0]          i_TX_Data,
  output logic                          o_TX_Ready,
  output logic                          o_TX,
  output logic                          o_TX_Active,
  output logic                          o_TX_Done,
  output logic                          o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

  // state | meaning
  // IDLE  | line high, waiting for a tick with data queued
  // START | start bit (low) for OVERSAMPLE ticks
  // DATA  | data bits LSB first, OVERSAMPLE ticks each
  // STOP  | stop period (high), OVERSAMPLE*STOP_BITS ticks

  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = PW + 1;
  localparam int STOP_TICKS = OVERSAMPLE * STOP_BITS;
  localparam int TW         = $clog2(STOP_TICKS + 1);
  localparam int BW         = $clog2(DATA_BITS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                 state;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   push, pop;
  logic                   bit_end, stop_end;

  assign push     = i_TX_DV && (count < CW'(FIFO_DEPTH));
  assign bit_end  = i_Sample_Tick && (tick_cnt == TW'(OVERSAMPLE - 1));
  assign stop_end = i_Sample_Tick && (tick_cnt == TW'(STOP_TICKS - 1));

  always_comb begin
    pop = 1'b0;
    case (state)
      S_IDLE:  pop = i_Sample_Tick && (count != '0);
      S_STOP:  pop = stop_end && (count != '0);
      default: pop = 1'b0;
    endcase
  end

  // Storage carries no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge i_CLK) begin
    if (push) mem[wr_ptr] <= i_TX_Data;
  end

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count      <= count + CW'(push) - CW'(pop);
      o_Overflow <= i_TX_DV && (count == CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state     <= S_IDLE;
      o_TX      <= 1'b1;
      o_TX_Done <= 1'b0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
    end else begin
      o_TX_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          o_TX <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            state    <= S_START;
            o_TX     <= 1'b0;
            tick_cnt <= '0;
            bit_idx  <= '0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state    <= S_DATA;
            o_TX     <= shift[0];
            tick_cnt <= '0;
            bit_idx  <= '0;
          end else if (i_Sample_Tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            tick_cnt <= '0;
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              state   <= S_STOP;
              o_TX    <= 1'b1;
              bit_idx <= '0;
            end else begin
              shift   <= shift >> 1;
              o_TX    <= shift[1];
              bit_idx <= bit_idx + BW'(1);
            end
          end else if (i_Sample_Tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        S_STOP: begin
          o_TX <= 1'b1;
          if (stop_end) begin
            o_TX_Done <= 1'b1;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            // Back-to-back frames skip IDLE so there is no gap after the stop bit.
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= S_START;
              o_TX  <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else if (i_Sample_Tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          o_TX  <= 1'b1;
        end
      endcase
    end
  end

  assign o_TX_Ready   = count < CW'(FIFO_DEPTH);
  assign o_TX_Active  = (state != S_IDLE) || (count != '0);
  assign o_FIFO_Count = count;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: framing, FIFO, overflow, two stop bits, reset abort.
// A bench-side serial decoder samples mid-bit and acts as the loopback receiver.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       tick_en;
  int         div = 0;
  logic       dv, dv2;
  logic [7:0] data;

  logic       ready, tx, active, done, ovf;
  logic [2:0] count;
  logic       ready2, tx2, active2, done2, ovf2;
  logic [2:0] count2;

  int nvec = 0;
  int nerr = 0;
  int done_cnt = 0;
  int ovf_cnt = 0;

  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .i_CLK(clk), .i_RESET_n(rst_n), .i_Sample_Tick(tick), .i_TX_DV(dv),
    .i_TX_Data(data), .o_TX_Ready(ready), .o_TX(tx), .o_TX_Active(active),
    .o_TX_Done(done), .o_Overflow(ovf), .o_FIFO_Count(count));

  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .i_CLK(clk), .i_RESET_n(rst_n), .i_Sample_Tick(tick), .i_TX_DV(dv2),
    .i_TX_Data(data), .o_TX_Ready(ready2), .o_TX(tx2), .o_TX_Active(active2),
    .o_TX_Done(done2), .o_Overflow(ovf2), .o_FIFO_Count(count2));

  always #5 clk = ~clk;

  // One tick every 4 clocks while enabled, changed on the falling edge.
  always @(negedge clk) begin
    if (tick_en) begin
      div  = (div + 1) % 4;
      tick = (div == 0);
    end else begin
      tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (ovf === 1'b1)  ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_burst(input int n, input logic [7:0] b0, b1, b2, b3, b4);
    logic [7:0] v [5];
    v = '{b0, b1, b2, b3, b4};
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      data = v[i];
      dv   = 1'b1;
      @(negedge clk);
    end
    dv = 1'b0;
  endtask

  // Wait for a start bit, then sample each bit at its centre (64 clocks per bit).
  // Returns in the middle of the stop bit; waited = clocks until the start edge.
  task automatic recv(output logic [7:0] b, output int waited, output logic frame_ok);
    b = '0;
    waited = 0;
    frame_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (tx !== 1'b0 && waited < 3000);
    if (tx !== 1'b0) begin
      frame_ok = 1'b0;
      return;
    end
    repeat (32) @(posedge clk);
    #1;
    if (tx !== 1'b0) frame_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (64) @(posedge clk);
      #1;
      b[i] = tx;
    end
    repeat (64) @(posedge clk);
    #1;
    if (tx !== 1'b1) frame_ok = 1'b0;
  endtask

  logic [7:0] b;
  int         w, n, d0;
  logic       ok, high_ok;

  initial begin
    rst_n = 1'b0; dv = 1'b0; dv2 = 1'b0; data = '0; tick_en = 1'b0; tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_count", count, 0);
    chk("rst_ready", ready, 1);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_tx", tx, 1);

    // Single byte with ticks running
    tick_en = 1'b1;
    d0 = done_cnt;
    wr_burst(1, 8'hA5, 0, 0, 0, 0);
    recv(b, w, ok);
    chk("t1_frame_ok", ok, 1);
    chk("t1_byte", b, 8'hA5);
    repeat (31) @(posedge clk);
    #1;
    chk("t1_done_early", done, 0);
    @(posedge clk); #1;
    chk("t1_done_edge", done, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_active_low", active, 0);

    // Back-to-back frames
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    wr_burst(2, 8'h55, 8'h0F, 0, 0, 0);
    chk("t2_count2", count, 2);
    tick_en = 1'b1;
    recv(b, w, ok);
    chk("t2_count1", count, 1);
    chk("t2_b0", {ok, b}, {1'b1, 8'h55});
    recv(b, w, ok);
    chk("t2_gap", w, 32);
    chk("t2_count0", count, 0);
    chk("t2_b1", {ok, b}, {1'b1, 8'h0F});
    repeat (40) @(posedge clk);
    #1;
    chk("t2_done_count", done_cnt - d0, 2);

    // Overflow with ticks held low
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    n = ovf_cnt;
    wr_burst(5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    @(negedge clk);
    chk("t3_count", count, 4);
    chk("t3_ready", ready, 0);
    chk("t3_ovf_pulses", ovf_cnt - n, 1);
    tick_en = 1'b1;
    recv(b, w, ok); chk("t3_b0", {ok, b}, {1'b1, 8'h11});
    recv(b, w, ok); chk("t3_b1", {ok, b}, {1'b1, 8'h22});
    recv(b, w, ok); chk("t3_b2", {ok, b}, {1'b1, 8'h33});
    recv(b, w, ok); chk("t3_b3", {ok, b}, {1'b1, 8'h44});
    repeat (800) @(posedge clk);
    #1;
    chk("t3_done_count", done_cnt - d0, 4);
    chk("t3_active", active, 0);
    chk("t3_tx_idle", tx, 1);

    // Two stop bits on the second instance
    @(negedge clk);
    data = 8'hFF; dv2 = 1'b1;
    @(negedge clk);
    dv2 = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (tx2 !== 1'b0 && n < 3000);
    chk("t4_start", tx2, 0);
    n = 0;
    high_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (n >= 64 && tx2 !== 1'b1) high_ok = 1'b0;
    end while (done2 !== 1'b1 && n < 3000);
    chk("t4_start_to_done", n, 704);
    chk("t4_line_high", high_ok, 1);
    @(posedge clk); #1;
    chk("t4_done_pulse", done2, 0);

    // Reset during bit 3 of 0x3C with 0x99 queued
    d0 = done_cnt;
    wr_burst(2, 8'h3C, 8'h99, 0, 0, 0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (tx !== 1'b0 && n < 3000);
    chk("t5_start", tx, 0);
    repeat (288) @(posedge clk);
    #1;
    chk("t5_bit3", tx, 1);
    chk("t5_queued", count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", tx, 1);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_active", active, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (800) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_idle_tx", tx, 1);
    wr_burst(1, 8'h81, 0, 0, 0, 0);
    recv(b, w, ok);
    chk("t5_after", {ok, b}, {1'b1, 8'h81});
    repeat (40) @(posedge clk);

    // Loopback through the bench decoder
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    wr_burst(4, 8'h00, 8'hFF, 8'h5A, 8'hC3, 0);
    tick_en = 1'b1;
    recv(b, w, ok); chk("t6_b0", {ok, b}, {1'b1, 8'h00});
    recv(b, w, ok); chk("t6_b1", {ok, b}, {1'b1, 8'hFF});
    recv(b, w, ok); chk("t6_b2", {ok, b}, {1'b1, 8'h5A});
    recv(b, w, ok); chk("t6_b3", {ok, b}, {1'b1, 8'hC3});
    repeat (40) @(posedge clk);
    #1;
    chk("t6_done_count", done_cnt - d0, 4);
    chk("t6_active", active, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Oversampled UART transmitter. It is the transmit-side counterpart of the existing UART receiver and shares the same baud/oversample tick generator. It frames bytes from a small write FIFO as 1 start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop bits, with no parity. It sits between the memory-mapped UART register block (writer side) and the FPGA TX pin.

Parameters:
DATA_BITS, 8, data bits per frame.
OVERSAMPLE, 16, sample ticks per bit period; must match the receiver.
STOP_BITS, 1, number of stop bits (1 or 2).
FIFO_DEPTH, 4, write FIFO entries; power of two, >= 2.

Ports:
i_CLK  in  1  system clock.
i_RESET_n  in  1  asynchronous active-low reset.
i_Sample_Tick  in  1  one-clock pulse per oversample period.
i_TX_DV  in  1  write strobe; pushes i_TX_Data when accepted.
i_TX_Data  in  DATA_BITS  byte to transmit.
o_TX_Ready  out  1  FIFO not full (registered count < FIFO_DEPTH).
o_TX  out  1  serial line; idle high; registered.
o_TX_Active  out  1  high when FSM != IDLE or FIFO non-empty.
o_TX_Done  out  1  one-clock pulse at the end of each frame's stop period.
o_Overflow  out  1  one-clock pulse when a write is dropped.
o_FIFO_Count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is asynchronous, active-low, on i_RESET_n; clock is i_CLK. Reset values: o_TX=1, FSM=IDLE, FIFO empty, o_FIFO_Count=0, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0, o_Overflow=0. Reset mid-frame aborts the frame and drives o_TX high immediately.
- FIFO push:
  - A push is accepted on a clock where i_TX_DV=1 and the registered count < FIFO_DEPTH.
  - If i_TX_DV=1 while the count == FIFO_DEPTH, the write is dropped and o_Overflow=1 for that next clock. This applies even when a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the count unchanged and keep data order.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO pop: only done by the FSM, and only when count > 0. A byte pushed into an empty FIFO cannot be popped in the same cycle.
- FSM states: IDLE, START, DATA, STOP. Tick counter and bit index both reset to 0 on entry to each state.
  - IDLE: o_TX=1. On a clock with i_Sample_Tick=1 and count > 0: pop the head into the shift register and go to START. o_TX=0 from the next clock.
  - START: o_TX=0. Count ticks. On the tick where counter == OVERSAMPLE-1, go to DATA and drive shift[0].
  - DATA: o_TX = current LSB. On the tick where counter == OVERSAMPLE-1, shift right. After bit DATA_BITS-1, go to STOP; otherwise increment the bit index.
  - STOP: o_TX=1. On the tick where counter == OVERSAMPLE*STOP_BITS-1:
    - o_TX_Done=1 for one clock.
    - If count > 0: pop and go directly to START (back-to-back, no idle gap).
    - Otherwise go to IDLE.
  - Any illegal state: go to IDLE, o_TX=1.
- Timing:
  - Every bit lasts exactly OVERSAMPLE tick periods; stop lasts OVERSAMPLE*STOP_BITS tick periods.
  - Latency from the accepting tick in IDLE to the falling edge of o_TX is one clock.
  - i_Sample_Tick has no effect on a clock where it is low.
- The shift register is loaded only on pop. A FIFO write never alters the byte currently being shifted.
- o_TX_Active drops to 0 on the clock after the final STOP→IDLE transition with the FIFO empty.

Test Plan:
1. Single byte: OVERSAMPLE=16, tick every 4 clocks, write 0xA5 -> o_TX shows 0 for 16 ticks, then 1,0,1,0,0,1,0,1 with 16 ticks each, then 1 for 16 ticks. o_TX_Done pulses once; o_TX_Active falls afterwards.
2. Back-to-back: write 0x55 then 0x0F on consecutive clocks -> two frames with no idle gap between the stop of 0x55 and the start of 0x0F. Exactly 2 o_TX_Done pulses; o_FIFO_Count goes 2→1→0.
3. Overflow: hold i_Sample_Tick low and write 0x11,0x22,0x33,0x44,0x55 on consecutive clocks -> count=4, o_TX_Ready=0, one o_Overflow pulse on the 5th write. Release the tick -> 0x11..0x44 are sent in order and 0x55 is never sent.
4. STOP_BITS=2: write 0xFF -> stop period lasts 32 ticks before o_TX_Done; the line stays high throughout.
5. Reset mid-frame: assert i_RESET_n=0 during bit 3 of 0x3C -> o_TX=1 immediately, count=0, no o_TX_Done. After release, a new write of 0x81 is sent cleanly.
6. Loopback: connect o_TX to the receiver with the same tick and parameters, send 0x00, 0xFF, 0x5A, 0xC3 -> receiver outputs the identical bytes in order, one data-valid pulse each.
